// File: rtl/nrzi_rx.sv
// nrzi_rx -- toggle-encoded (NRZI) serial receiver with sync hunt and
// valid/ready byte output.
//
// The line carries the Q output of a transmit-side toggle flip-flop, so a
// decoded 1 is a level change and a decoded 0 is no change. The receiver
// hunts for the SYNC pattern, then assembles payload bytes MSB first until
// IDLE_LEN consecutive decoded 0s end the frame.
//
// Ports
//   clk        in   1  rising-edge clock
//   rst        in   1  asynchronous active-low reset
//   bit_en     in   1  line_q is sampled on edges where bit_en=1
//   line_q     in   1  toggle-encoded line level
//   data       out  8  received byte
//   valid      out  1  data holds an unconsumed byte
//   ready      in   1  consumer accepts data when valid & ready on an edge
//   in_frame   out  1  receiver is inside a frame (state DATA)
//   frame_end  out  1  one-cycle pulse after a frame terminates
//   overflow   out  1  sticky: a completed byte was dropped
module nrzi_rx #(
   parameter logic [7:0] SYNC     = 8'hA5,
   parameter int          IDLE_LEN = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bit_en,
   input  logic       line_q,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       in_frame,
   output logic       frame_end,
   output logic       overflow
);

   typedef enum logic [0:0] {
      HUNT = 1'b0,
      DATA = 1'b1
   } state_t;

   localparam logic [3:0] IDLE_CNT = 4'(IDLE_LEN);

   state_t      state_r, state_nx_s;
   logic        prev_q_r, prev_q_nx_s;
   logic [7:0]  hist_r, hist_nx_s;
   logic [6:0]  shift_r, shift_nx_s;
   logic [2:0]  bit_cnt_r, bit_cnt_nx_s;
   logic [3:0]  run_cnt_r, run_cnt_nx_s;
   logic [7:0]  data_r, data_nx_s;
   logic        valid_r, valid_nx_s;
   logic        frame_end_r, frame_end_nx_s;
   logic        overflow_r, overflow_nx_s;

   logic        dbit_s;
   logic [7:0]  hist_shift_s;
   logic [7:0]  byte_s;
   logic [3:0]  run_inc_s;
   logic        byte_done_s;
   logic        term_s;

   assign dbit_s       = line_q ^ prev_q_r;
   assign hist_shift_s = {hist_r[6:0], dbit_s};
   assign byte_s       = {shift_r, dbit_s};
   assign run_inc_s    = run_cnt_r + 4'd1;

   // Decode, sync hunt, byte assembly and idle-run termination.
   always_comb begin
      state_nx_s   = state_r;
      prev_q_nx_s  = prev_q_r;
      hist_nx_s    = hist_r;
      shift_nx_s   = shift_r;
      bit_cnt_nx_s = bit_cnt_r;
      run_cnt_nx_s = run_cnt_r;
      byte_done_s  = 1'b0;
      term_s       = 1'b0;
      if (bit_en) begin
         prev_q_nx_s = line_q;
         case (state_r)
            HUNT: begin
               hist_nx_s = hist_shift_s;
               if (hist_shift_s == SYNC) begin
                  state_nx_s   = DATA;
                  bit_cnt_nx_s = 3'd0;
                  run_cnt_nx_s = 4'd0;
               end else begin
                  state_nx_s   = HUNT;
               end
            end
            DATA: begin
               run_cnt_nx_s = dbit_s ? 4'd0 : run_inc_s;
               // Termination overrides a byte completing on the same bit.
               if (!dbit_s && (run_inc_s == IDLE_CNT)) begin
                  term_s       = 1'b1;
                  state_nx_s   = HUNT;
                  hist_nx_s    = 8'h00;
                  shift_nx_s   = 7'd0;
                  bit_cnt_nx_s = 3'd0;
                  run_cnt_nx_s = 4'd0;
               end else begin
                  shift_nx_s   = byte_s[6:0];
                  bit_cnt_nx_s = bit_cnt_r + 3'd1;
                  byte_done_s  = (bit_cnt_r == 3'd7);
               end
            end
            default: begin
               state_nx_s = HUNT;
            end
         endcase
      end else begin
         prev_q_nx_s = prev_q_r;
      end
   end

   // Output handshake: load, hold, accept and overflow detection.
   always_comb begin
      data_nx_s      = data_r;
      valid_nx_s     = valid_r;
      overflow_nx_s  = overflow_r;
      frame_end_nx_s = term_s;
      if (byte_done_s) begin
         if (valid_r && !ready) begin
            overflow_nx_s = 1'b1;
         end else begin
            data_nx_s  = byte_s;
            valid_nx_s = 1'b1;
         end
      end else if (valid_r && ready) begin
         valid_nx_s = 1'b0;
      end else begin
         valid_nx_s = valid_r;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= HUNT;
         prev_q_r    <= 1'b0;
         hist_r      <= 8'h00;
         shift_r     <= 7'd0;
         bit_cnt_r   <= 3'd0;
         run_cnt_r   <= 4'd0;
         data_r      <= 8'h00;
         valid_r     <= 1'b0;
         frame_end_r <= 1'b0;
         overflow_r  <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         prev_q_r    <= prev_q_nx_s;
         hist_r      <= hist_nx_s;
         shift_r     <= shift_nx_s;
         bit_cnt_r   <= bit_cnt_nx_s;
         run_cnt_r   <= run_cnt_nx_s;
         data_r      <= data_nx_s;
         valid_r     <= valid_nx_s;
         frame_end_r <= frame_end_nx_s;
         overflow_r  <= overflow_nx_s;
      end
   end

   assign data      = data_r;
   assign valid     = valid_r;
   assign in_frame  = (state_r == DATA);
   assign frame_end = frame_end_r;
   assign overflow  = overflow_r;

endmodule

// File: tb/tb_nrzi_rx.sv
// tb_nrzi_rx -- self-checking bench for nrzi_rx.
// A vector table covers sync acquisition, first byte and frame end; hand
// sequences cover backpressure/overflow, accept-and-load, bit_en gating,
// termination coinciding with byte completion, and mid-frame reset.
// Expected bytes go into a scoreboard queue when their bits are driven and
// are popped whenever the DUT presents valid with ready high.
module tb_nrzi_rx;

   typedef struct {
      logic       bit_en;
      logic       ready;
      logic       line;
      logic       in_frame;
      logic       valid;
      logic       frame_end;
      logic [7:0] data;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       bit_en;
   logic       line_q;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       in_frame;
   logic       frame_end;
   logic       overflow;

   int         n_vec;
   int         n_fail;
   logic [7:0] exp_q[$];
   vec_t       tbl[24];
   logic       line_tx;
   logic [7:0] sync_line;
   logic [7:0] byte_line;
   logic [7:0] b69;
   logic [31:0] rnd;

   nrzi_rx #(.SYNC(8'hA5), .IDLE_LEN(8)) dut (
      .clk(clk), .rst(rst), .bit_en(bit_en), .line_q(line_q),
      .data(data), .valid(valid), .ready(ready), .in_frame(in_frame),
      .frame_end(frame_end), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock: scoreboard check at the falling edge, then step past the rising edge.
   task automatic tick();
      @(negedge clk);
      if (valid === 1'b1 && ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL sb_unexpected: got byte %h expected none", data);
         end else begin
            chk8("sb_data", data, exp_q.pop_front());
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      line_tx = line_tx ^ b;
      line_q  = line_tx;
      bit_en  = 1'b1;
      tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   initial begin
      n_vec     = 0;
      n_fail    = 0;
      rst       = 1'b1;
      bit_en    = 1'b0;
      line_q    = 1'b0;
      ready     = 1'b1;
      line_tx   = 1'b0;
      sync_line = 8'b11000110;
      byte_line = 8'b00101000;
      b69       = 8'h69;

      for (int i = 0; i < 8; i++)
         tbl[i] = '{1'b1, 1'b1, sync_line[7-i], (i == 7), 1'b0, 1'b0, 8'h00};
      for (int i = 8; i < 16; i++)
         tbl[i] = '{1'b1, 1'b1, byte_line[15-i], 1'b1, (i == 15), 1'b0,
                    (i == 15) ? 8'h3C : 8'h00};
      for (int i = 16; i < 24; i++)
         tbl[i] = '{1'b1, 1'b1, 1'b0, (i < 21), 1'b0, (i == 21), 8'h3C};

      // Reset state
      #2 rst = 1'b0;
      #2;
      chk8("rst_data", data, 8'h00);
      chk1("rst_valid", valid, 1'b0);
      chk1("rst_in_frame", in_frame, 1'b0);
      chk1("rst_frame_end", frame_end, 1'b0);
      chk1("rst_overflow", overflow, 1'b0);
      tick();
      tick();
      rst = 1'b1;

      // Table: sync A5, byte 3C, then constant line until the frame ends
      for (int i = 0; i < 24; i++) begin
         bit_en = tbl[i].bit_en;
         ready  = tbl[i].ready;
         line_q = tbl[i].line;
         if (tbl[i].valid) exp_q.push_back(tbl[i].data);
         tick();
         chk1($sformatf("vec%0d_in_frame", i), in_frame, tbl[i].in_frame);
         chk1($sformatf("vec%0d_valid", i), valid, tbl[i].valid);
         chk1($sformatf("vec%0d_frame_end", i), frame_end, tbl[i].frame_end);
         chk8($sformatf("vec%0d_data", i), data, tbl[i].data);
      end
      line_tx = 1'b0;

      // Backpressure: 3C held, C3 dropped, overflow sticky
      ready = 1'b0;
      send_byte(8'hA5);
      chk1("bp_in_frame", in_frame, 1'b1);
      exp_q.push_back(8'h3C);
      send_byte(8'h3C);
      chk1("bp_valid1", valid, 1'b1);
      chk1("bp_ovf0", overflow, 1'b0);
      send_byte(8'hC3);
      chk8("bp_data_hold", data, 8'h3C);
      chk1("bp_valid_hold", valid, 1'b1);
      chk1("bp_overflow", overflow, 1'b1);
      bit_en = 1'b0;
      ready  = 1'b1;
      tick();
      chk1("bp_accept_clear", valid, 1'b0);

      // Gating: bit_en=0 with random line must change nothing
      for (int k = 0; k < 16; k++) begin
         rnd    = $urandom;
         line_q = rnd[0];
         bit_en = 1'b0;
         tick();
         chk1("gate_in_frame", in_frame, 1'b1);
         chk1("gate_valid", valid, 1'b0);
         chk1("gate_frame_end", frame_end, 1'b0);
         chk1("gate_overflow", overflow, 1'b1);
         chk8("gate_data", data, 8'h3C);
      end
      line_q = line_tx;

      // Accept and load on the same edge
      ready = 1'b0;
      exp_q.push_back(8'h3C);
      send_byte(8'h3C);
      chk1("al_valid", valid, 1'b1);
      exp_q.push_back(8'h69);
      for (int i = 7; i >= 1; i--) send_bit(b69[i]);
      ready = 1'b1;
      send_bit(b69[0]);
      chk1("al_valid_stays", valid, 1'b1);
      chk8("al_data_new", data, 8'h69);

      // Termination coincides with byte completion: no byte emitted
      for (int k = 0; k < 8; k++) begin
         send_bit(1'b0);
         chk1($sformatf("tc%0d_in_frame", k), in_frame, (k < 7));
         chk1($sformatf("tc%0d_frame_end", k), frame_end, (k == 7));
      end
      chk1("tc_valid", valid, 1'b0);
      bit_en = 1'b0;
      tick();
      chk1("tc_frame_end_drop", frame_end, 1'b0);

      // Mid-byte reset
      send_byte(8'hA5);
      chk1("mr_in_frame", in_frame, 1'b1);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      bit_en = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk8("mr_data", data, 8'h00);
      chk1("mr_valid", valid, 1'b0);
      chk1("mr_in_frame0", in_frame, 1'b0);
      chk1("mr_frame_end", frame_end, 1'b0);
      chk1("mr_overflow", overflow, 1'b0);
      tick();
      tick();
      chk1("mr_frame_end_hold", frame_end, 1'b0);
      line_tx = 1'b0;
      line_q  = 1'b0;
      rst     = 1'b1;

      // Fresh SYNC required after reset
      send_byte(8'h3C);
      chk1("rs_hunt1", in_frame, 1'b0);
      send_byte(8'h3C);
      chk1("rs_hunt2", in_frame, 1'b0);
      chk1("rs_valid", valid, 1'b0);
      send_byte(8'hA5);
      chk1("rs_sync", in_frame, 1'b1);
      exp_q.push_back(8'h96);
      send_byte(8'h96);
      chk1("rs_valid_byte", valid, 1'b1);
      chk8("rs_data", data, 8'h96);
      bit_en = 1'b0;
      tick();
      tick();
      n_vec++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
